eclk_bus_sequencer: RTL and testbench

//  Consumes clk and the e enable from the clock generator: rebuilds the 68000 E-clock waveform and runs
//  6800-style VPA/VMA synchronous bus cycles for the slow 8-bit peripherals (CIAs).

---
 rtl/eclk_bus_sequencer.sv | 137 +++++++++++++
 tb/tb_eclk_bus_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/eclk_bus_sequencer.sv
// Rebuilds the 68000 E clock from the generator's e enable and runs 6800-style VPA/VMA
// bus cycles for slow 8-bit peripherals; CPU side is a level req with a one-clk ack pulse.
module eclk_bus_sequencer #(
  parameter int EPERIOD = 10,
  parameter int EHIGH   = 4,
  parameter int VMA_PH  = 3
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       e_i,
  input  logic       req_i,
  input  logic       rw_i,
  input  logic [7:0] wdata_i,
  input  logic [7:0] per_rdata_i,
  output logic       eclk_o,
  output logic       vma_o,
  output logic       per_rw_o,
  output logic [7:0] per_wdata_o,
  output logic       strobe_o,
  output logic       ack_o,
  output logic [7:0] rdata_o
);

  localparam logic [3:0] PH_LAST = 4'(EPERIOD - 1);
  localparam logic [3:0] PH_HIGH = 4'(EPERIOD - EHIGH);
  localparam logic [3:0] PH_VMA  = 4'(VMA_PH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYNC,
    ST_ACCESS,
    ST_HOLD
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] ph_q, ph_d;
  logic       synced_q, synced_d;
  logic       vma_q, vma_d;
  logic       strobe_q, strobe_d;
  logic       ack_q, ack_d;
  logic       per_rw_q, per_rw_d;
  logic [7:0] per_wdata_q, per_wdata_d;
  logic [7:0] rdata_q, rdata_d;

  // e marks ph==0, so the cycle after it is ph==1; a reload always beats the increment.
  always_comb begin
    ph_d     = ph_q;
    synced_d = synced_q;
    if (e_i) begin
      ph_d     = 4'd1;
      synced_d = 1'b1;
    end else if (ph_q == PH_LAST) begin
      ph_d = 4'd0;
    end else begin
      ph_d = ph_q + 4'd1;
    end
  end

  always_comb begin
    state_d     = state_q;
    vma_d       = vma_q;
    strobe_d    = 1'b0;
    ack_d       = 1'b0;
    per_rw_d    = per_rw_q;
    per_wdata_d = per_wdata_q;
    rdata_d     = rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_i) begin
          per_rw_d    = rw_i;
          per_wdata_d = wdata_i;
          state_d     = ST_SYNC;
        end
      end
      ST_SYNC: begin
        if (!req_i) begin
          state_d = ST_IDLE;
        end else if (synced_q && (ph_q == PH_VMA)) begin
          vma_d   = 1'b1;
          state_d = ST_ACCESS;
        end
      end
      // Once vma is out the peripheral has seen the address, so the cycle must finish.
      ST_ACCESS: begin
        if (ph_q == PH_LAST) begin
          vma_d    = 1'b0;
          strobe_d = 1'b1;
          ack_d    = 1'b1;
          if (per_rw_q) begin
            rdata_d = per_rdata_i;
          end
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!req_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      ph_q        <= 4'd0;
      synced_q    <= 1'b0;
      vma_q       <= 1'b0;
      strobe_q    <= 1'b0;
      ack_q       <= 1'b0;
      per_rw_q    <= 1'b1;
      per_wdata_q <= 8'h00;
      rdata_q     <= 8'h00;
    end else begin
      state_q     <= state_d;
      ph_q        <= ph_d;
      synced_q    <= synced_d;
      vma_q       <= vma_d;
      strobe_q    <= strobe_d;
      ack_q       <= ack_d;
      per_rw_q    <= per_rw_d;
      per_wdata_q <= per_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  // Gated by synced so the free-running counter stays invisible until the first e.
  assign eclk_o      = synced_q && (ph_q >= PH_HIGH);
  assign vma_o       = vma_q;
  assign strobe_o    = strobe_q;
  assign ack_o       = ack_q;
  assign per_rw_o    = per_rw_q;
  assign per_wdata_o = per_wdata_q;
  assign rdata_o     = rdata_q;

endmodule

// File: tb/tb_eclk_bus_sequencer.sv
// Directed bench for eclk_bus_sequencer: E-clock shape, read, write, abort, held req, async reset.
module tb_eclk_bus_sequencer;

  logic       clk;
  logic       reset;
  logic       e;
  logic       req;
  logic       rw;
  logic [7:0] wdata;
  logic [7:0] per_rdata;
  logic       eclk;
  logic       vma;
  logic       per_rw;
  logic [7:0] per_wdata;
  logic       strobe;
  logic       ack;
  logic [7:0] rdata;

  int n_checks = 0;
  int n_fail   = 0;
  int tb_ph    = 0;
  bit e_run    = 0;

  eclk_bus_sequencer dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .e_i         (e),
    .req_i       (req),
    .rw_i        (rw),
    .wdata_i     (wdata),
    .per_rdata_i (per_rdata),
    .eclk_o      (eclk),
    .vma_o       (vma),
    .per_rw_o    (per_rw),
    .per_wdata_o (per_wdata),
    .strobe_o    (strobe),
    .ack_o       (ack),
    .rdata_o     (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  // tb_ph is the bench's own phase: e is driven in the tb_ph==0 cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    tb_ph = (tb_ph == 9) ? 0 : tb_ph + 1;
    e = e_run && (tb_ph == 0);
  endtask

  task automatic wait_ph(input int p);
    for (int i = 0; i < 10 && tb_ph != p; i++) tick();
  endtask

  task automatic test_reset();
    bit seen;
    bit exp_eclk;
    reset = 1'b1; e = 1'b0; req = 1'b0; rw = 1'b1; wdata = 8'h00; per_rdata = 8'h00;
    tick(); tick();
    n_checks++;
    if ({eclk, vma, strobe, ack, per_rw, per_wdata, rdata} !== {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_values: eclk=%b vma=%b strobe=%b ack=%b per_rw=%b per_wdata=%h rdata=%h, want 0 0 0 0 1 00 00",
               eclk, vma, strobe, ack, per_rw, per_wdata, rdata);
    end
    reset = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      n_checks++;
      if (eclk !== 1'b0 || vma !== 1'b0) begin
        n_fail++;
        $display("FAIL pre_sync_hold: cycle %0d eclk=%b vma=%b, want 0 0", i, eclk, vma);
      end
    end
    e_run = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      exp_eclk = seen && (tb_ph >= 6);
      n_checks++;
      if (eclk !== exp_eclk) begin
        n_fail++;
        $display("FAIL eclk_shape: ph=%0d eclk=%b, want %b", tb_ph, eclk, exp_eclk);
      end
      if (e) seen = 1'b1;
    end
  endtask

  task automatic test_read();
    bit exp_vma;
    wait_ph(0);
    req = 1'b1; rw = 1'b1; per_rdata = 8'hA5;
    for (int k = 1; k <= 10; k++) begin
      tick();
      exp_vma = (tb_ph >= 4) && (k < 10);
      n_checks++;
      if (vma !== exp_vma || ack !== (k == 10) || strobe !== (k == 10)) begin
        n_fail++;
        $display("FAIL read_timing: k=%0d vma=%b ack=%b strobe=%b, want vma=%b ack/strobe=%b",
                 k, vma, ack, strobe, exp_vma, (k == 10));
      end
    end
    n_checks++;
    if (rdata !== 8'hA5 || per_rw !== 1'b1) begin
      n_fail++;
      $display("FAIL read_data: rdata=%h per_rw=%b, want a5 1", rdata, per_rw);
    end
    req = 1'b0;
    tick();
    n_checks++;
    if (ack !== 1'b0 || strobe !== 1'b0) begin
      n_fail++;
      $display("FAIL read_pulse_width: ack=%b strobe=%b, want 0 0", ack, strobe);
    end
  endtask

  task automatic test_write();
    bit exp_vma;
    wait_ph(4);
    req = 1'b1; rw = 1'b0; wdata = 8'h3C; per_rdata = 8'h5A;
    tick();
    rw = 1'b1; wdata = 8'hFF;
    n_checks++;
    if (per_wdata !== 8'h3C || per_rw !== 1'b0) begin
      n_fail++;
      $display("FAIL write_latch: per_wdata=%h per_rw=%b, want 3c 0", per_wdata, per_rw);
    end
    for (int k = 2; k <= 16; k++) begin
      tick();
      exp_vma = (k >= 10) && (k <= 15);
      n_checks++;
      if (vma !== exp_vma || ack !== (k == 16)) begin
        n_fail++;
        $display("FAIL write_timing: k=%0d vma=%b ack=%b, want vma=%b ack=%b", k, vma, ack, exp_vma, (k == 16));
      end
    end
    n_checks++;
    if (rdata !== 8'hA5 || per_wdata !== 8'h3C) begin
      n_fail++;
      $display("FAIL write_rdata_kept: rdata=%h per_wdata=%h, want a5 3c", rdata, per_wdata);
    end
    req = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    int hits;
    wait_ph(5);
    req = 1'b1; rw = 1'b1; per_rdata = 8'h99;
    hits = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (vma || strobe || ack) hits++;
    end
    req = 1'b0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (vma || strobe || ack) hits++;
    end
    n_checks++;
    if (hits !== 0) begin
      n_fail++;
      $display("FAIL abort_quiet: %0d cycles with vma/strobe/ack, want 0", hits);
    end
    n_checks++;
    if (rdata !== 8'hA5) begin
      n_fail++;
      $display("FAIL abort_rdata: rdata=%h, want a5", rdata);
    end
  endtask

  task automatic test_held_req();
    int acks;
    int first_ack;
    wait_ph(0);
    req = 1'b1; rw = 1'b1; per_rdata = 8'h77;
    acks = 0; first_ack = -1;
    for (int k = 1; k <= 50; k++) begin
      tick();
      if (ack) begin
        acks++;
        if (first_ack < 0) first_ack = k;
      end
    end
    n_checks++;
    if (acks !== 1 || first_ack !== 10) begin
      n_fail++;
      $display("FAIL held_req_single: acks=%0d first_at=%0d, want 1 at 10", acks, first_ack);
    end
    n_checks++;
    if (rdata !== 8'h77) begin
      n_fail++;
      $display("FAIL held_req_rdata: rdata=%h, want 77", rdata);
    end
    req = 1'b0;
    tick();
    req = 1'b1; rw = 1'b0; wdata = 8'h11;
    acks = 0;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (ack) acks++;
    end
    n_checks++;
    if (acks !== 1 || per_wdata !== 8'h11 || rdata !== 8'h77) begin
      n_fail++;
      $display("FAIL held_req_rearm: acks=%0d per_wdata=%h rdata=%h, want 1 11 77", acks, per_wdata, rdata);
    end
    req = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    int bad;
    bit seen;
    bit exp_eclk;
    wait_ph(0);
    req = 1'b1; rw = 1'b1; per_rdata = 8'hEE;
    for (int i = 0; i < 7; i++) tick();
    n_checks++;
    if (vma !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_pre: vma=%b at ph=%0d, want 1", vma, tb_ph);
    end
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if ({vma, strobe, ack, eclk, per_rw, rdata} !== {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00}) begin
      n_fail++;
      $display("FAIL areset_immediate: vma=%b strobe=%b ack=%b eclk=%b per_rw=%b rdata=%h, want 0 0 0 0 1 00",
               vma, strobe, ack, eclk, per_rw, rdata);
    end
    req = 1'b0;
    tick();
    reset = 1'b0;
    bad = 0; seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      exp_eclk = seen && (tb_ph >= 6);
      if (ack || strobe || vma || (eclk !== exp_eclk)) bad++;
      if (e) seen = 1'b1;
    end
    n_checks++;
    if (bad !== 0 || rdata !== 8'h00) begin
      n_fail++;
      $display("FAIL areset_after: %0d bad cycles rdata=%h, want 0 bad and 00", bad, rdata);
    end
    wait_ph(0);
    req = 1'b1; rw = 1'b1; per_rdata = 8'h42;
    bad = -1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (ack && bad < 0) bad = k;
    end
    n_checks++;
    if (bad !== 10 || rdata !== 8'h42) begin
      n_fail++;
      $display("FAIL areset_idle_after: ack at %0d rdata=%h, want 10 42", bad, rdata);
    end
    req = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_abort();
    test_held_req();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
